// File: rtl/matrix_alu_sequencer.sv
// Command sequencer for the 5x5 matrix ALU: loads operand rows, starts the ALU, streams result rows.
// Optional performance counters (op_count, stall_count) are enabled by defining SEQ_PERF_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// LOAD_A  | accepting operand A rows 0..4
// LOAD_B  | accepting operand B rows 0..4 (binary ops only)
// EXEC    | one-cycle alu_start pulse, latency counter loaded
// WAIT    | counting down the ALU latency
// CAPTURE | registering ALU result and overflow
// SEND    | streaming result rows 0..4
module matrix_alu_sequencer #(
  parameter int ROWS         = 5,
  parameter int ROW_W        = 40,
  parameter int MULT_LATENCY = 8,
  parameter int COMB_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [7:0]              cmd_scalar,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROW_W-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROW_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    out_overflow,
  output logic                    cmd_error,
  output logic                    busy,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0]             op_count,
  output logic [15:0]             stall_count,
`endif
  output logic [2:0]              alu_op_code,
  output logic [ROWS*ROW_W-1:0]   alu_matrix_a,
  output logic [ROWS*ROW_W-1:0]   alu_matrix_b,
  output logic [7:0]              alu_scalar,
  output logic                    alu_start,
  input  logic [ROWS*ROW_W-1:0]   alu_result,
  input  logic                    alu_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WAIT, S_CAPTURE, S_SEND
  } state_t;

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  state_t state, state_nxt;
  logic [ROWS-1:0][ROW_W-1:0] mat_a, mat_b, result_q;
  logic [2:0] op_q;
  logic [7:0] scalar_q;
  logic       need_b;
  logic       ovf_q;
  logic [2:0] row_cnt;
  logic [7:0] lat_cnt;
  logic       op_bad;
  logic       op_binary;
  logic       row_last;
  logic       alu_drive;

  assign op_bad    = (cmd_op == 3'b101) || (cmd_op == 3'b111);
  assign op_binary = (cmd_op == 3'b000) || (cmd_op == 3'b001) || (cmd_op == 3'b110);
  assign row_last  = (row_cnt == LAST_ROW);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    alu_start = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !op_bad) state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && row_last) state_nxt = need_b ? S_LOAD_B : S_EXEC;
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && row_last) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:    if (lat_cnt == 8'd0) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_SEND;
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = row_last;
        if (out_ready && row_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mat_a     <= '0;
      mat_b     <= '0;
      result_q  <= '0;
      op_q      <= '0;
      scalar_q  <= '0;
      need_b    <= 1'b0;
      ovf_q     <= 1'b0;
      row_cnt   <= '0;
      lat_cnt   <= '0;
      cmd_error <= 1'b0;
    end else begin
      cmd_error <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q      <= cmd_op;
          scalar_q  <= cmd_scalar;
          need_b    <= op_binary;
          row_cnt   <= '0;
          cmd_error <= op_bad;
        end
        S_LOAD_A: if (in_valid) begin
          mat_a[row_cnt] <= in_data;
          row_cnt        <= row_last ? 3'd0 : row_cnt + 3'd1;
          // unary ops must see a zero B operand, not the previous command's
          if (row_last && !need_b) mat_b <= '0;
        end
        S_LOAD_B: if (in_valid) begin
          mat_b[row_cnt] <= in_data;
          row_cnt        <= row_last ? 3'd0 : row_cnt + 3'd1;
        end
        S_EXEC:  lat_cnt <= (op_q == 3'b110) ? 8'(MULT_LATENCY) : 8'(COMB_LATENCY);
        S_WAIT:  if (lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
        S_CAPTURE: begin
          result_q <= alu_result;
          ovf_q    <= alu_overflow;
          row_cnt  <= '0;
        end
        S_SEND: if (out_ready) row_cnt <= row_last ? 3'd0 : row_cnt + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (state == S_CAPTURE) op_count <= op_count + 16'd1;
      if (state == S_SEND && !out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

  // operands are presented to the ALU only while it is working on them
  assign alu_drive    = (state == S_EXEC) || (state == S_WAIT) || (state == S_CAPTURE);
  assign alu_op_code  = alu_drive ? op_q : 3'b000;
  assign alu_matrix_a = alu_drive ? mat_a : '0;
  assign alu_matrix_b = alu_drive ? mat_b : '0;
  assign alu_scalar   = alu_drive ? scalar_q : 8'd0;
  assign out_data     = (state == S_SEND) ? result_q[row_cnt] : '0;
  assign out_overflow = ovf_q;
  assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Directed bench for matrix_alu_sequencer with a bytewise behavioural ALU model.
// Counter checks are compiled in when SEQ_PERF_CNT_EN is defined.
module tb_matrix_alu_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [7:0]   cmd_scalar = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [39:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [39:0]  out_data;
  logic         out_last;
  logic         out_overflow;
  logic         cmd_error;
  logic         busy;
  logic [2:0]   alu_op_code;
  logic [199:0] alu_matrix_a;
  logic [199:0] alu_matrix_b;
  logic [7:0]   alu_scalar;
  logic         alu_start;
  logic [199:0] alu_result;
  logic         alu_overflow;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0]  op_count;
  logic [15:0]  stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int starts = 0;
  int errs = 0;
  int last_cyc = 0;
  int first_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_start) starts <= starts + 1;
    if (cmd_error) errs <= errs + 1;
  end

  // ALU model: 001 subtract, 011 negate A, everything else adds; 110 flags overflow
  function automatic logic [199:0] alu_fn(input logic [2:0] op, input logic [199:0] a,
                                          input logic [199:0] b);
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) begin
      case (op)
        3'b001:  r[i*8 +: 8] = a[i*8 +: 8] - b[i*8 +: 8];
        3'b011:  r[i*8 +: 8] = 8'd0 - a[i*8 +: 8];
        default: r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
      endcase
    end
    return r;
  endfunction

  assign alu_result   = alu_fn(alu_op_code, alu_matrix_a, alu_matrix_b);
  assign alu_overflow = (alu_op_code == 3'b110);

  matrix_alu_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_scalar(cmd_scalar),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_overflow(out_overflow), .cmd_error(cmd_error), .busy(busy),
`ifdef SEQ_PERF_CNT_EN
    .op_count(op_count), .stall_count(stall_count),
`endif
    .alu_op_code(alu_op_code), .alu_matrix_a(alu_matrix_a), .alu_matrix_b(alu_matrix_b),
    .alu_scalar(alu_scalar), .alu_start(alu_start),
    .alu_result(alu_result), .alu_overflow(alu_overflow)
  );

  task automatic check_val(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] sc);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) check_val("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_scalar = sc;
    tick();
    cmd_valid = 1'b0;
  endtask

  // row r carries five copies of the byte v0 + r*step
  task automatic send_rows(input logic [7:0] v0, input logic [7:0] step);
    logic [7:0] b;
    int n;
    for (int r = 0; r < 5; r++) begin
      b = v0 + 8'(r) * step;
      in_valid = 1'b1;
      in_data = {5{b}};
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      if (!in_ready) check_val("in_ready_wait", in_ready, 1'b1);
      tick();
      last_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  // stalls[4r+3:4r] is the number of cycles out_ready is held low on row r
  task automatic recv_rows(input logic [7:0] v0, input logic [7:0] step,
                           input logic [19:0] stalls, input logic exp_ovf);
    logic [7:0]  e;
    logic [39:0] d0;
    logic        stable;
    int n;
    for (int r = 0; r < 5; r++) begin
      e = v0 + 8'(r) * step;
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      if (!out_valid) check_val("out_valid_wait", out_valid, 1'b1);
      if (r == 0) first_cyc = cyc;
      d0 = out_data;
      stable = 1'b1;
      repeat (int'(stalls[r*4 +: 4])) begin
        tick();
        if (out_data !== d0 || !out_valid) stable = 1'b0;
      end
      if (stalls[r*4 +: 4] != 4'd0) check_val("stall_stable", stable, 1'b1);
      check_val("out_data", out_data, {5{e}});
      check_val("out_last", out_last, (r == 4));
      check_val("out_overflow", out_overflow, exp_ovf);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check_val("idle_after_burst", busy, 1'b0);
  endtask

  initial begin
    int s0;
    do_reset();
    check_val("rst_cmd_ready", cmd_ready, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_in_ready", in_ready, 1'b0);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_cmd_error", cmd_error, 1'b0);
    check_val("rst_alu_start", alu_start, 1'b0);

    // op 000: 01 + 02 -> 03 rows, one start pulse
    s0 = starts;
    send_cmd(3'b000, 8'h00);
    send_rows(8'h01, 8'h00);
    send_rows(8'h02, 8'h00);
    recv_rows(8'h03, 8'h00, 20'h00000, 1'b0);
    check_val("add_start_count", starts - s0, 1);

    // op 010 unary with distinct rows and stalls; B must have been cleared
    send_cmd(3'b010, 8'h00);
    send_rows(8'h10, 8'h11);
    check_val("unary_no_b_ready", in_ready, 1'b0);
    recv_rows(8'h10, 8'h11, 20'h33333, 1'b0);

    // op 110: latency 8 -> first out_valid 11 cycles after last B row
    send_cmd(3'b110, 8'h00);
    send_rows(8'h11, 8'h00);
    send_rows(8'h22, 8'h00);
    recv_rows(8'h33, 8'h00, 20'h00000, 1'b1);
    check_val("mult_latency", first_cyc - last_cyc, 11);

    // unsupported ops
    s0 = starts;
    send_cmd(3'b101, 8'h00);
    check_val("err101_pulse", cmd_error, 1'b1);
    check_val("err101_idle", busy, 1'b0);
    tick();
    check_val("err101_single", cmd_error, 1'b0);
    send_cmd(3'b111, 8'h00);
    check_val("err111_pulse", cmd_error, 1'b1);
    check_val("err111_idle", cmd_ready, 1'b1);
    tick();
    check_val("err111_single", cmd_error, 1'b0);
    check_val("err_cycles", errs, 2);
    check_val("err_no_start", starts - s0, 0);

    // reset during WAIT aborts the operation
    send_cmd(3'b110, 8'h00);
    send_rows(8'h01, 8'h00);
    send_rows(8'h01, 8'h00);
    repeat (3) tick();
    check_val("wait_busy", busy, 1'b1);
    do_reset();
    check_val("abort_cmd_ready", cmd_ready, 1'b1);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_ovf", out_overflow, 1'b0);
    check_val("abort_alu_a", alu_matrix_a, '0);
    check_val("abort_out_data", out_data, '0);
    repeat (12) tick();
    check_val("abort_no_output", out_valid, 1'b0);

    // op 011 negates: 05 -> FB
    send_cmd(3'b011, 8'h00);
    send_rows(8'h05, 8'h00);
    recv_rows(8'hFB, 8'h00, 20'h00000, 1'b0);

    // two more commands with 3 + 1 stall cycles in total
    send_cmd(3'b010, 8'h00);
    send_rows(8'h40, 8'h01);
    recv_rows(8'h40, 8'h01, 20'h00003, 1'b0);
    send_cmd(3'b001, 8'h00);
    send_rows(8'h10, 8'h00);
    send_rows(8'h03, 8'h00);
    recv_rows(8'h0D, 8'h00, 20'h10000, 1'b0);
`ifdef SEQ_PERF_CNT_EN
    check_val("op_count", op_count, 16'd3);
    check_val("stall_count", stall_count, 16'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_alu_sequencer.md
Name: matrix_alu_sequencer

Overview:
- Command-level controller for the 5x5 signed-8-bit matrix ALU (200-bit operands, 3-bit op code).
- Accepts one command, loads operand rows over a 40-bit stream into internal A/B registers, and drives the ALU with a `start` pulse.
- Waits the operation's latency, captures result and overflow, then streams the 5 result rows out.
- Sits between the host/bus interface and the ALU; the ALU itself is instantiated outside this block.

Parameters:
- ROWS, 5, matrix rows per operand and per result.
- ROW_W, 40, bits per row (5 elements x 8 bits).
- MULT_LATENCY, 8, cycles from `alu_start` to a valid result for op 3'b110; legal range 1..255.
- COMB_LATENCY, 1, cycles from operand drive to capture for ops 000–100.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  ALU op code
- cmd_scalar  in  8  signed scalar for op 100
- in_valid  in  1  operand row valid
- in_ready  out  1  block accepts operand row
- in_data  in  40  operand row
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts result row
- out_data  out  40  result row
- out_last  out  1  marks result row 4
- out_overflow  out  1  captured ALU overflow; held stable for the whole result burst
- cmd_error  out  1  one-cycle pulse when an unsupported op is rejected
- busy  out  1  high in every state except IDLE
- alu_op_code  out  3  to ALU
- alu_matrix_a  out  200  to ALU
- alu_matrix_b  out  200  to ALU
- alu_scalar  out  8  to ALU
- alu_start  out  1  to ALU; single-cycle pulse
- alu_result  in  200  from ALU
- alu_overflow  in  1  from ALU

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; all outputs 0 except cmd_ready=1.
  - A/B/result/op/scalar registers cleared; row and latency counters cleared.
  - Reset mid-operation aborts everything; no partial output completes.
- Row packing: row r occupies bits [40r+39:40r]. Row 0 is transferred first, for both input and output.
- Transfer rule: a transfer occurs when valid & ready are both high at a clk edge. data is sampled only on transfer.
- IDLE:
  - cmd_ready=1.
  - On a cmd_valid transfer, latch op and scalar.
  - ops 000, 001, 110 -> LOAD_A with need_b=1.
  - ops 010, 011, 100 -> LOAD_A with need_b=0.
  - ops 101, 111 -> pulse cmd_error for 1 cycle and remain in IDLE. No ALU activity.
- LOAD_A:
  - in_ready=1; each transfer writes the row selected by the 3-bit counter.
  - After row 4: go to LOAD_B if need_b, else EXEC. The counter wraps to 0.
  - Before entering EXEC from LOAD_A, B is cleared to 0.
- LOAD_B: same as LOAD_A, filling B; after row 4 go to EXEC.
- EXEC (1 cycle):
  - alu_op_code, alu_matrix_a, alu_matrix_b and alu_scalar are driven from registers. They stay driven from EXEC through CAPTURE.
  - alu_start=1 for this cycle only.
  - Latency counter is loaded with MULT_LATENCY for op 110, else COMB_LATENCY. Go to WAIT.
- WAIT: decrement the counter each cycle; when it reaches 0 go to CAPTURE.
- CAPTURE (1 cycle): register alu_result and alu_overflow; go to SEND.
- SEND:
  - out_valid=1; out_data=result row[counter]; out_last=1 when counter==4.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - After the row-4 transfer go to IDLE.
  - out_overflow stays valid until the next CAPTURE.
- Latency from the last operand transfer to first out_valid is latency+3 cycles: 11 for op 110 and 4 for the other ops, at default parameters.
- cmd_valid is ignored outside IDLE (cmd_ready=0).
- in_valid is ignored outside LOAD_A/LOAD_B.
- Back-to-back: a command may be accepted the cycle after the final out transfer. IDLE lasts at least 1 cycle.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined:
  - Adds output `op_count` [15:0]. It increments on each CAPTURE, wraps at 16'hFFFF -> 0, and resets to 0.
  - Adds output `stall_count` [15:0]. It increments each SEND cycle with out_ready=0, saturates at 16'hFFFF, and resets to 0.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Op 000: A rows all 8'h01, B rows all 8'h02, ALU model adds -> rows 40'h0303030303; alu_start pulses once; out_last on the 5th row; out_overflow=0.
- Op 010, stall consumer: 5 A rows only, out_ready low 3 cycles per row -> out_data stable while stalled; no B rows accepted (in_ready=0 after row 4).
- Op 110, MULT_LATENCY=8, ALU model asserts overflow -> first out_valid exactly 11 cycles after the last B transfer; out_overflow=1 across all 5 rows.
- Op 101 then op 111 -> cmd_error 1-cycle pulse each; state stays IDLE; alu_start never asserted.
- Reset during WAIT, then op 011 with A rows 8'h05 -> all outputs 0 after reset; new command produces rows of 8'hFB.
- With SEQ_PERF_CNT_EN defined: 3 commands, 4 total stall cycles -> op_count=3, stall_count=4.
